inv_sub_layer_iter: RTL and testbench
=====================================

Name: inv_sub_layer_iter

Overview:
- Iterative inverse of the Ascon 5-bit S-box layer over a 320-bit state (five 64-bit lanes x0..x4).
- Processes SLICES bit-slices per cycle, in place, with valid/ready handshakes on both sides.
- Sits beside the permutation as the undo path, used by state-recovery/debug and by the permutation verification bench for round-trip checks.
- Slice i is the 5-bit word {x0[i],x1[i],x2[i],x3[i],x4[i]}, with x0 as the MSB.

Parameters:
- SLICES, 8, bit-slices inverted per cycle; legal values 1, 2, 4, 8, 16, 32, 64.
- NSTEP, 64/SLICES, localparam; number of RUN cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input state valid.
- in_ready  out  1  block can accept a state; high only in IDLE.
- x0, x1, x2, x3, x4  in  64 each  input lanes, sampled on accept.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- y0, y1, y2, y3, y4  out  64 each  result lanes, driven directly from the working registers.
- busy  out  1  high in RUN or DONE.
- chk_err  out  1  sticky self-check error; tied 0 when the optional feature is absent.

Behaviour:
- Reset (asynchronous, active-high): FSM goes to IDLE, step counter to 0, working registers to 0, chk_err to 0.
  - Outputs during reset: in_ready=1, out_valid=0, busy=0, y*=0.
- Inverse S-box, indexed by input value 00..1F:
  - 14 1A 07 0D 00 09 0E 12 0A 06 1D 01 19 15 13 1E
  - 18 16 0B 11 03 05 1C 1F 17 1B 04 08 0F 0C 10 02
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: load x0..x4 into the working registers, set cnt=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, replace slices [cnt*SLICES +: SLICES] of all five lanes with their inverse S-box values; cnt increments.
  - After the update with cnt==NSTEP-1, go to DONE and reset cnt to 0.
- DONE:
  - out_valid=1; y* are held stable until out_valid & out_ready.
  - On that handshake, go to IDLE.
  - Input cannot be accepted in the same cycle as the output handshake; in_ready is 0 in DONE.
- Latency: with the accept edge as E0, slice groups are updated at edges E1..E_NSTEP, and out_valid is high from E_NSTEP. For SLICES=8, that is 8 cycles.
- Minimum initiation interval: NSTEP+2 cycles.
- out_ready and in_valid are ignored outside DONE and IDLE respectively.
- Reset asserted mid-RUN or mid-DONE: the operation is abandoned with no output; the block returns to IDLE.
- If SLICES does not divide 64 exactly, elaboration fails (generate-time error).
- The block is purely bitwise; there is no arithmetic beyond cnt, which is $clog2(NSTEP) bits wide (minimum 1).

Optional Feature:
- Macro: INV_SUB_SELFCHECK_EN.
- Defined:
  - An extra 320-bit shadow register captures the input on accept.
  - Each RUN cycle, every freshly inverted slice is passed through the forward S-box and compared with the shadow slice.
  - Any mismatch sets chk_err, which stays high until rst.
- Undefined: no shadow register, no forward S-box, and chk_err is tied to 0.
- Timing, handshakes, and y* are identical in both builds.

Decomposition:
- Package ascon_pkg holds:
  - LANE_W=64, STATE_W=320.
  - The 32-entry INV_SBOX constant array and the forward SBOX array, the latter used by the self-check.
  - FSM state typedef {IDLE, RUN, DONE}.
- One natural sub-module: inv_sbox_lookup, a combinational 5-in/5-out table lookup, instantiated SLICES times.

Test Plan:
- All lanes 0 (every slice 00) -> y0=FFFF_FFFF_FFFF_FFFF, y1=0, y2=FFFF_FFFF_FFFF_FFFF, y3=0, y4=0 (slice value 14).
- Round trip: x2=all ones, other lanes 0 (forward image of 0) -> all y=0. Also run 1000 random states through the forward layer then this block, and require the result to equal the original state.
- Latency with SLICES=8: out_valid rises exactly 8 cycles after the accept edge and in_ready is 0 throughout. Repeat with SLICES=1 (64 cycles) and SLICES=64 (1 cycle).
- Backpressure: hold out_ready=0 for 20 cycles in DONE with in_valid=1 -> y* stable, in_ready=0, no second accept. Release -> IDLE next cycle, then the new accept.
- Reset mid-RUN (step 3 of 8) -> all outputs return to reset values immediately and out_valid never pulses. The next accepted state completes correctly.
- With INV_SUB_SELFCHECK_EN defined, force one working-register bit via the bench mid-RUN -> chk_err rises and stays high until rst. A clean run keeps chk_err=0.

Source files
------------

// File: rtl/ascon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : ascon_pkg                                              |
// | Description : Shared widths, Ascon S-box tables and FSM encoding for |
// |               the iterative inverse S-box layer.                     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package ascon_pkg;

   localparam int LANE_W  = 64;
   localparam int STATE_W = 320;

   // Inverse Ascon S-box, indexed by the 5-bit slice {x0,x1,x2,x3,x4}
   localparam logic [4:0] INV_SBOX [32] = '{
      5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
      5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
      5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
      5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02
   };

   // Forward Ascon S-box, used to re-encrypt freshly inverted slices
   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
      5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
      5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
      5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
   };

   // Controller states
   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t DONE = 2'd2;

endpackage : ascon_pkg
`default_nettype wire

// File: rtl/inv_sbox_lookup.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : inv_sbox_lookup                                        |
// | Description : Combinational 5-in/5-out inverse Ascon S-box lookup.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module inv_sbox_lookup
   import ascon_pkg::*;
(
   input  logic [4:0] sin_i,
   output logic [4:0] sout_o
);

   assign sout_o = INV_SBOX[sin_i];

endmodule : inv_sbox_lookup
`default_nettype wire

// File: rtl/inv_sub_layer_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : inv_sub_layer_iter                                     |
// | Description : Iterative inverse of the Ascon S-box layer over a      |
// |               320-bit state, SLICES bit-slices per cycle, in place.  |
// |               Optional self-check: define INV_SUB_SELFCHECK_EN to    |
// |               re-encrypt each inverted slice against a shadow copy   |
// |               of the input and raise a sticky chk_err on mismatch.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module inv_sub_layer_iter
   import ascon_pkg::*;
#(
   parameter int SLICES = 8
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [LANE_W-1:0] x0,
   input  logic [LANE_W-1:0] x1,
   input  logic [LANE_W-1:0] x2,
   input  logic [LANE_W-1:0] x3,
   input  logic [LANE_W-1:0] x4,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LANE_W-1:0] y0,
   output logic [LANE_W-1:0] y1,
   output logic [LANE_W-1:0] y2,
   output logic [LANE_W-1:0] y3,
   output logic [LANE_W-1:0] y4,
   output logic              busy,
   output logic              chk_err
);

   localparam int NSTEP = LANE_W / SLICES;
   localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSTEP - 1);

   generate
      if ((LANE_W % SLICES) != 0) begin : g_bad_slices
         $error("inv_sub_layer_iter: SLICES must divide 64 exactly");
      end
      if (STATE_W != 5 * LANE_W) begin : g_bad_state
         $error("inv_sub_layer_iter: state width must be five lanes");
      end
   endgenerate

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q,   cnt_d;
   // lane_q[0] is x0 (slice MSB) ... lane_q[4] is x4 (slice LSB)
   logic [0:4][LANE_W-1:0]  lane_q,  lane_d;

   logic [6:0]              base_w;
   logic [SLICES-1:0][5:0]  idx_w;
   logic [SLICES-1:0][4:0]  sl_in_w;
   logic [SLICES-1:0][4:0]  sl_out_w;

   // first bit position of the slice group handled this step
   assign base_w = 7'(cnt_q) * 7'(SLICES);

   generate
      for (genvar s = 0; s < SLICES; s++) begin : g_slice
         assign idx_w[s]   = base_w[5:0] + 6'(s);
         assign sl_in_w[s] = {lane_q[0][idx_w[s]], lane_q[1][idx_w[s]],
                              lane_q[2][idx_w[s]], lane_q[3][idx_w[s]],
                              lane_q[4][idx_w[s]]};
         inv_sbox_lookup u_lut (
            .sin_i  (sl_in_w[s]),
            .sout_o (sl_out_w[s])
         );
      end
   endgenerate

   // next-state logic: load on accept, invert one slice group per RUN cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lane_d  = lane_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = RUN;
               cnt_d   = '0;
               lane_d  = {x0, x1, x2, x3, x4};
            end
         end
         RUN: begin
            for (int s = 0; s < SLICES; s++) begin
               for (int l = 0; l < 5; l++) begin
                  lane_d[l][idx_w[s]] = sl_out_w[s][4-l];
               end
            end
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state, step counter and working registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         lane_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lane_q  <= lane_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN) || (state_q == DONE);
   assign y0        = lane_q[0];
   assign y1        = lane_q[1];
   assign y2        = lane_q[2];
   assign y3        = lane_q[3];
   assign y4        = lane_q[4];

`ifdef INV_SUB_SELFCHECK_EN
   logic [0:4][LANE_W-1:0]  shadow_q;
   logic [SLICES-1:0]       mism_w;
   logic                    chk_err_q;

   generate
      for (genvar s = 0; s < SLICES; s++) begin : g_chk
         assign mism_w[s] = SBOX[sl_out_w[s]] !=
                            {shadow_q[0][idx_w[s]], shadow_q[1][idx_w[s]],
                             shadow_q[2][idx_w[s]], shadow_q[3][idx_w[s]],
                             shadow_q[4][idx_w[s]]};
      end
   endgenerate

   // shadow copy of the accepted state and sticky mismatch flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q  <= '0;
         chk_err_q <= 1'b0;
      end else begin
         if (state_q == IDLE && in_valid) begin
            shadow_q <= {x0, x1, x2, x3, x4};
         end
         if (state_q == RUN && (|mism_w)) begin
            chk_err_q <= 1'b1;
         end
      end
   end

   assign chk_err = chk_err_q;
`else
   assign chk_err = 1'b0;
`endif

endmodule : inv_sub_layer_iter
`default_nettype wire

// File: tb/tb_inv_sub_layer_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_inv_sub_layer_iter                                  |
// | Description : Directed self-checking bench for inv_sub_layer_iter.   |
// |               Self-check section active with INV_SUB_SELFCHECK_EN.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_inv_sub_layer_iter;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] ZERO = 64'h0;

   // forward Ascon S-box held independently by the bench
   localparam logic [4:0] FWD [32] = '{
      5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
      5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
      5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
      5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
   };

   logic clk = 1'b0;
   logic rst;
   logic in_valid;
   logic out_ready;
   logic or_tie;
   logic [0:4][63:0] xin;

   wire             in_ready,   out_valid,   busy,   chk_err;
   wire             in_ready_1, out_valid_1, busy_1, chk_err_1;
   wire             in_ready_64, out_valid_64, busy_64, chk_err_64;
   wire [0:4][63:0] y8, y1, y64;

   int total = 0;
   int bad   = 0;

   inv_sub_layer_iter #(.SLICES(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .x0(xin[0]), .x1(xin[1]), .x2(xin[2]), .x3(xin[3]), .x4(xin[4]),
      .out_valid(out_valid), .out_ready(out_ready),
      .y0(y8[0]), .y1(y8[1]), .y2(y8[2]), .y3(y8[3]), .y4(y8[4]),
      .busy(busy), .chk_err(chk_err)
   );

   inv_sub_layer_iter #(.SLICES(1)) dut_s1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_1),
      .x0(xin[0]), .x1(xin[1]), .x2(xin[2]), .x3(xin[3]), .x4(xin[4]),
      .out_valid(out_valid_1), .out_ready(or_tie),
      .y0(y1[0]), .y1(y1[1]), .y2(y1[2]), .y3(y1[3]), .y4(y1[4]),
      .busy(busy_1), .chk_err(chk_err_1)
   );

   inv_sub_layer_iter #(.SLICES(64)) dut_s64 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_64),
      .x0(xin[0]), .x1(xin[1]), .x2(xin[2]), .x3(xin[3]), .x4(xin[4]),
      .out_valid(out_valid_64), .out_ready(or_tie),
      .y0(y64[0]), .y1(y64[1]), .y2(y64[2]), .y3(y64[3]), .y4(y64[4]),
      .busy(busy_64), .chk_err(chk_err_64)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [0:4][63:0] fwd_layer(input logic [0:4][63:0] s);
      logic [4:0]       w;
      logic [0:4][63:0] r;
      r = '0;
      for (int i = 0; i < 64; i++) begin
         w = FWD[{s[0][i], s[1][i], s[2][i], s[3][i], s[4][i]}];
         for (int l = 0; l < 5; l++) r[l][i] = w[4-l];
      end
      return r;
   endfunction

   // one full transaction on the SLICES=8 instance, output taken immediately
   task automatic do_op(input logic [0:4][63:0] s, output logic [0:4][63:0] r,
                        output int lat, output bit rdy_seen);
      lat      = 0;
      rdy_seen = 1'b0;
      r        = '0;
      xin      = s;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      while (!out_valid && lat < 200) begin
         rdy_seen = rdy_seen | in_ready;
         @(posedge clk);
         lat++;
         #1;
      end
      check("op_done", 320'(out_valid), 320'(1'b1));
      if (out_valid) begin
         r         = y8;
         out_ready = 1'b1;
         @(posedge clk);
         #1 out_ready = 1'b0;
      end
   endtask

   logic [0:4][63:0] res, orig, snap;
   int  lat, lat8, lat1, lat64;
   bit  rs, ok;
`ifdef INV_SUB_SELFCHECK_EN
   logic fb;
`endif

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; or_tie = 1'b1; xin = '0;
      #1;
      check("rst_in_ready",  320'(in_ready),  320'(1'b1));
      check("rst_out_valid", 320'(out_valid), 320'(1'b0));
      check("rst_busy",      320'(busy),      320'(1'b0));
      check("rst_y",         y8,              320'(0));
      check("rst_chk_err",   320'(chk_err),   320'(1'b0));
      check("rst_s1",  {in_ready_1,  busy_1,  chk_err_1},  320'(3'b100));
      check("rst_s64", {in_ready_64, busy_64, chk_err_64}, 320'(3'b100));
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // latency for SLICES = 8 / 1 / 64 with all-zero input
      lat8 = -1; lat1 = -1; lat64 = -1; rs = 1'b0;
      xin = '0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int c = 1; c <= 80; c++) begin
         rs = rs | in_ready;
         @(posedge clk);
         #1;
         if (lat8  < 0 && out_valid)    lat8  = c;
         if (lat1  < 0 && out_valid_1)  begin lat1  = c; res = y1;  end
         if (lat64 < 0 && out_valid_64) begin lat64 = c; snap = y64; end
      end
      check("lat_s8",  320'(lat8),  320'(8));
      check("lat_s1",  320'(lat1),  320'(64));
      check("lat_s64", 320'(lat64), 320'(1));
      check("lat_in_ready", 320'(rs), 320'(1'b0));
      check("zero_s8",  y8,   {ONES, ZERO, ONES, ZERO, ZERO});
      check("zero_s1",  res,  {ONES, ZERO, ONES, ZERO, ZERO});
      check("zero_s64", snap, {ONES, ZERO, ONES, ZERO, ZERO});
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;

      // directed vectors with hand-computed results
      do_op({ZERO, ZERO, ONES, ZERO, ZERO}, res, lat, rs);
      check("x2_ones", res, 320'(0));
      check("op_in_ready", 320'(rs), 320'(1'b0));
      do_op({ONES, ZERO, ZERO, ZERO, ZERO}, res, lat, rs);
      check("x0_ones", res, {ONES, ONES, ZERO, ZERO, ZERO});
      do_op({ZERO, ZERO, ZERO, ZERO, ONES}, res, lat, rs);
      check("x4_ones", res, {ONES, ONES, ZERO, ONES, ZERO});
      do_op({64'hAAAA_AAAA_AAAA_AAAA, ZERO, ZERO, ZERO, ZERO}, res, lat, rs);
      check("x0_alt", res, {ONES, 64'hAAAA_AAAA_AAAA_AAAA,
                            64'h5555_5555_5555_5555, ZERO, ZERO});

      // backpressure in DONE with a competing input
      xin = {ONES, ZERO, ZERO, ZERO, ZERO}; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 200) begin @(posedge clk); lat++; #1; end
      check("bp_done", 320'(out_valid), 320'(1'b1));
      xin = {ZERO, ZERO, ZERO, ZERO, ONES}; in_valid = 1'b1;
      snap = y8; ok = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (y8 !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
      end
      check("bp_hold", 320'(ok), 320'(1'b1));
      check("bp_value", snap, {ONES, ONES, ZERO, ZERO, ZERO});
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("bp_idle", {in_ready, out_valid}, 320'(2'b10));
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("bp_accept", {busy, in_ready}, 320'(2'b10));
      lat = 0;
      while (!out_valid && lat < 200) begin @(posedge clk); lat++; #1; end
      check("bp_second", y8, {ONES, ONES, ZERO, ONES, ZERO});
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;

      // reset at step 3 of 8
      xin = {ONES, ZERO, ZERO, ZERO, ZERO}; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_out", {in_ready, out_valid, busy}, 320'(3'b100));
      check("mid_rst_y", y8, 320'(0));
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      ok = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         if (out_valid) ok = 1'b0;
      end
      check("mid_rst_no_out", 320'(ok), 320'(1'b1));
      do_op('0, res, lat, rs);
      check("after_rst", res, {ONES, ZERO, ONES, ZERO, ZERO});
      check("after_rst_lat", 320'(lat), 320'(8));

      // random round trips through the bench's forward layer
      for (int n = 0; n < 1000; n++) begin
         for (int l = 0; l < 5; l++) orig[l] = {$urandom(), $urandom()};
         do_op(fwd_layer(orig), res, lat, rs);
         check("roundtrip", res, orig);
      end
      check("chk_err_clean", 320'(chk_err), 320'(1'b0));

`ifdef INV_SUB_SELFCHECK_EN
      // corrupt a not-yet-processed bit mid-RUN
      xin = '0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      fb = dut.lane_q[0][63];
      force dut.lane_q[0][63] = ~fb;
      @(posedge clk);
      #1 release dut.lane_q[0][63];
      lat = 0;
      while (!out_valid && lat < 200) begin @(posedge clk); lat++; #1; end
      check("selfchk_raise", 320'(chk_err), 320'(1'b1));
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      do_op('0, res, lat, rs);
      check("selfchk_sticky", 320'(chk_err), 320'(1'b1));
      rst = 1'b1;
      #1;
      check("selfchk_rst", 320'(chk_err), 320'(1'b0));
      @(posedge clk);
      #1 rst = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_inv_sub_layer_iter
`default_nettype wire
